tinynpu_seq: RTL and testbench
==============================

# tinynpu_seq

Upstream command sequencer for the TinyNPU core. It accepts a val/rdy byte stream carrying one weight matrix followed by one or more input vectors. It converts that stream into the core's load, MAC and output strobes: `w_load_val` / `w_load_sel`, `x_load_val`, `mac_val` and `out_val`. It also reports busy and done status to the host.

## Interface

Parameters:
- `SIZE`, 4, array dimension; `SIZE` is a power of two and at least 2.
- `NBITS`, 8, data word width.
- `MAC_CYCLES`, 2*SIZE, number of cycles `mac_val` is held per vector.

Ports:
- `clk`  in  1  clock; one clock domain only.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  launch a job; sampled only in IDLE.
- `num_vec`  in  8  number of input vectors in the job; captured at start.
- `reuse_w`  in  1  skip the weight load; captured at start; effective only with the `_EN` macro defined.
- `in_msg`  in  NBITS  stream data.
- `in_val`  in  1  stream valid.
- `in_rdy`  out  1  stream ready.
- `w_in`  out  NBITS  weight word to the core (registered).
- `w_load_val`  out  1  weight load strobe (registered).
- `w_load_sel`  out  $clog2(SIZE)  weight row select (registered).
- `x_in`  out  NBITS  input word to the core (registered).
- `x_load_val`  out  1  input load strobe (registered).
- `mac_val`  out  1  MAC enable (registered).
- `out_val`  out  1  output drain enable (registered).
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at job completion.
- `trace_state`  out  3  current state encoding.

## Operation

States and encodings: IDLE=0, LOAD_W=1, LOAD_X=2, MAC=3, OUT=4.

Transitions:
- IDLE -> LOAD_W when `start` is high. IDLE -> LOAD_X instead when reuse is effective (see below).
- LOAD_W: `in_rdy`=1. Accepts exactly SIZE*SIZE words, then moves to LOAD_X.
- LOAD_X: `in_rdy`=1. Accepts exactly SIZE words, then moves to MAC.
- MAC: holds for MAC_CYCLES cycles, then moves to OUT.
- OUT: holds for SIZE cycles.
  - If the vector counter is non-zero after decrement, OUT -> LOAD_X.
  - Otherwise OUT -> IDLE and `done` pulses.

Special cases:
- `num_vec`=0: weights are loaded (unless reuse applies), then the block goes directly to IDLE with a `done` pulse; LOAD_X is never entered.
- A handshake is `in_val & in_rdy`. `in_rdy`=0 in IDLE, MAC and OUT, and `in_val` is ignored there.
- Weight words arrive row-major. `w_load_sel` = word_index / SIZE, i.e. the upper bits of a `$clog2(SIZE*SIZE)`-bit counter.
- `start` while busy is ignored; `num_vec` and `reuse_w` are not re-captured.
- `w_loaded` flag: set when LOAD_W completes, cleared by `rst`.

Reset values: every output is 0 and the state is IDLE. Reset mid-job aborts immediately, discards partial words and counters, and produces no `done` pulse.

## Timing

- `start` high in cycle t: state is LOAD_W (or LOAD_X) at t+1, and `in_rdy` is high from t+1.
- Handshake in cycle c:
  - `w_in`/`x_in` equal the word at c+1.
  - The matching load strobe is high only at c+1.
  - `w_load_sel` is valid alongside `w_load_val`.
- Back-to-back handshakes give back-to-back strobes. Gaps in `in_val` stall the block with no timeout.
- The last handshake of a phase in cycle c moves the state at c+1, and `in_rdy` is 0 at c+1 when the next state is MAC.
- Last x handshake in cycle c:
  - The final `x_load_val` is at c+1.
  - `mac_val` is high for cycles c+2 through c+1+MAC_CYCLES.
  - `out_val` is high for the SIZE cycles immediately following, with no bubble between `mac_val` and `out_val`.
- `done` is high in the cycle after the last `out_val` cycle. `busy` is low in that same cycle, and a new `start` is accepted then.
- Strobes are mutually exclusive: at most one of `w_load_val`, `x_load_val`, `mac_val`, `out_val` is high in any cycle.
- `x_in`/`w_in` hold their last value when their strobe is low.

## Configuration

- `TINYNPU_SEQ_WREUSE_EN`, defined: `reuse_w`=1 at start together with `w_loaded`=1 skips LOAD_W and goes IDLE -> LOAD_X. `reuse_w`=1 with `w_loaded`=0 still loads weights.
- `TINYNPU_SEQ_WREUSE_EN`, not defined: `reuse_w` is ignored and every job begins with LOAD_W. The port remains present.

## Test plan

- Reset with `rst` high for 2 cycles: all outputs 0, `trace_state`=0, and `start` with `rst` high has no effect.
- SIZE=4, `num_vec`=1, 20 words 1..20 streamed back-to-back:
  - 16 `w_load_val` pulses, with `w_load_sel` = 0,0,0,0,1,...,3 and `w_in` = 1..16.
  - 4 `x_load_val` pulses with `x_in` = 17..20.
  - 8 `mac_val` cycles, then 4 `out_val` cycles, then a `done` pulse exactly 1 cycle later.
- Stalling with `in_val` toggling 1,0,1,0 during LOAD_X: strobes appear only one cycle after each handshake, and MAC starts 2 cycles after the 4th handshake.
- `num_vec`=3: the sequence returns from OUT to LOAD_X twice, giving 3 MAC/OUT bursts and exactly one `done`. `start` pulsed mid-job is ignored.
- `num_vec`=0: weight load only, then `done`; zero `x_load_val`/`mac_val`/`out_val` pulses.
- With the macro defined:
  - Second job with `reuse_w`=1: `in_rdy` phase accepts only 4 words and no `w_load_val` pulses occur.
  - After `rst` mid-job, a `reuse_w`=1 job reloads all 16 weights.

Source files
------------

// File: rtl/tinynpu_seq.sv
// tinynpu_seq: upstream command sequencer for the TinyNPU core.
// Turns a val/rdy byte stream (one SIZE x SIZE weight matrix, then num_vec
// input vectors) into the core's weight/input load, MAC and output strobes.
// Optional build macro: TINYNPU_SEQ_WREUSE_EN lets reuse_w skip the weight
// load when an earlier job already loaded weights since the last reset.
module tinynpu_seq #(
    parameter int SIZE       = 4,
    parameter int NBITS      = 8,
    parameter int MAC_CYCLES = 2 * SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              num_vec,
    input  logic                    reuse_w,
    input  logic [NBITS-1:0]        in_msg,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [NBITS-1:0]        w_in,
    output logic                    w_load_val,
    output logic [$clog2(SIZE)-1:0] w_load_sel,
    output logic [NBITS-1:0]        x_in,
    output logic                    x_load_val,
    output logic                    mac_val,
    output logic                    out_val,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              trace_state
);
    localparam int SW   = $clog2(SIZE);
    localparam int CW   = 2 * SW;  // SIZE is a power of two, so SIZE*SIZE words need 2*SW bits
    localparam int TMAX = (MAC_CYCLES > SIZE) ? MAC_CYCLES : SIZE;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] W_LAST   = CW'(SIZE * SIZE - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(SIZE - 1);
    localparam logic [TW-1:0] MAC_LAST = TW'(MAC_CYCLES - 1);
    localparam logic [TW-1:0] OUT_LAST = TW'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_X = 3'd2,
        MAC    = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;      // word index within the current load phase
    logic [TW-1:0]    tmr_reg, tmr_next;      // cycle index within MAC / OUT
    logic [7:0]       vec_reg, vec_next;      // vectors still to process
    logic             w_loaded_reg;
    logic             fin;                    // job completes this cycle
    logic             done_pend_reg;
    logic             hs;
    logic             reuse_eff;
    logic [7:0]       vec_dec;

    logic [NBITS-1:0] w_in_reg, x_in_reg;
    logic [SW-1:0]    w_sel_reg;
    logic             w_val_reg, x_val_reg, mac_reg, out_reg, done_reg;

`ifdef TINYNPU_SEQ_WREUSE_EN
    assign reuse_eff = reuse_w & w_loaded_reg;
`else
    // Reuse is compiled out: the port and flag exist but never steer the FSM.
    logic unused_reuse;
    assign unused_reuse = reuse_w ^ w_loaded_reg;
    assign reuse_eff    = 1'b0;
`endif

    assign in_rdy      = (state_reg == LOAD_W) || (state_reg == LOAD_X);
    assign hs          = in_val & in_rdy;
    assign busy        = (state_reg != IDLE);
    assign trace_state = state_reg;
    assign vec_dec     = vec_reg - 8'd1;

    assign w_in       = w_in_reg;
    assign w_load_val = w_val_reg;
    assign w_load_sel = w_sel_reg;
    assign x_in       = x_in_reg;
    assign x_load_val = x_val_reg;
    assign mac_val    = mac_reg;
    assign out_val    = out_reg;
    assign done       = done_reg;

    // Next-state, counter and completion logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmr_next   = tmr_reg;
        vec_next   = vec_reg;
        fin        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    vec_next = num_vec;
                    cnt_next = '0;
                    tmr_next = '0;
                    if (!reuse_eff) begin
                        state_next = LOAD_W;
                    end else if (num_vec == 8'd0) begin
                        fin = 1'b1;
                    end else begin
                        state_next = LOAD_X;
                    end
                end
            end
            LOAD_W: begin
                if (hs) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == W_LAST) begin
                        cnt_next = '0;
                        if (vec_reg == 8'd0) begin
                            state_next = IDLE;
                            fin        = 1'b1;
                        end else begin
                            state_next = LOAD_X;
                        end
                    end
                end
            end
            LOAD_X: begin
                if (hs) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == X_LAST) begin
                        cnt_next   = '0;
                        tmr_next   = '0;
                        state_next = MAC;
                    end
                end
            end
            MAC: begin
                tmr_next = tmr_reg + 1'b1;
                if (tmr_reg == MAC_LAST) begin
                    tmr_next   = '0;
                    state_next = OUT;
                end
            end
            OUT: begin
                tmr_next = tmr_reg + 1'b1;
                if (tmr_reg == OUT_LAST) begin
                    tmr_next = '0;
                    vec_next = vec_dec;
                    if (vec_dec != 8'd0) begin
                        state_next = LOAD_X;
                    end else begin
                        state_next = IDLE;
                        fin        = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and the sticky weights-loaded flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            tmr_reg      <= '0;
            vec_reg      <= '0;
            w_loaded_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmr_reg   <= tmr_next;
            vec_reg   <= vec_next;
            if (state_reg == LOAD_W && hs && cnt_reg == W_LAST) begin
                w_loaded_reg <= 1'b1;
            end
        end
    end

    // Registered strobes and data; done trails the final out_val by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_in_reg      <= '0;
            x_in_reg      <= '0;
            w_sel_reg     <= '0;
            w_val_reg     <= 1'b0;
            x_val_reg     <= 1'b0;
            mac_reg       <= 1'b0;
            out_reg       <= 1'b0;
            done_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            w_val_reg     <= (state_reg == LOAD_W) && hs;
            x_val_reg     <= (state_reg == LOAD_X) && hs;
            mac_reg       <= (state_reg == MAC);
            out_reg       <= (state_reg == OUT);
            done_pend_reg <= fin;
            done_reg      <= done_pend_reg;
            if (state_reg == LOAD_W && hs) begin
                w_in_reg  <= in_msg;
                w_sel_reg <= cnt_reg[CW-1:SW];
            end
            if (state_reg == LOAD_X && hs) begin
                x_in_reg <= in_msg;
            end
        end
    end
endmodule

// File: tb/tb_tinynpu_seq.sv
// tb_tinynpu_seq: randomized bench for tinynpu_seq. Each job is first laid out
// as a cycle-indexed schedule (stimulus plus expected outputs) derived from the
// sequencer's phase timing rules, then replayed against the DUT.
module tb_tinynpu_seq;
    localparam int SIZE  = 4;
    localparam int NBITS = 8;
    localparam int MC    = 2 * SIZE;
    localparam int SW    = $clog2(SIZE);
    localparam int ML    = 1024;

    logic             clk = 1'b0;
    logic             rst, start, reuse_w, in_val;
    logic [7:0]       num_vec;
    logic [NBITS-1:0] in_msg;
    logic             in_rdy, w_load_val, x_load_val, mac_val, out_val, busy, done;
    logic [NBITS-1:0] w_in, x_in;
    logic [SW-1:0]    w_load_sel;
    logic [2:0]       trace_state;

    always #5 clk = ~clk;

    tinynpu_seq #(.SIZE(SIZE), .NBITS(NBITS), .MAC_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .reuse_w(reuse_w),
        .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
        .w_in(w_in), .w_load_val(w_load_val), .w_load_sel(w_load_sel),
        .x_in(x_in), .x_load_val(x_load_val), .mac_val(mac_val), .out_val(out_val),
        .busy(busy), .done(done), .trace_state(trace_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle behaviour and stimulus for one job.
    logic [2:0]       e_state [ML];
    bit               e_wv [ML], e_xv [ML], e_mac [ML], e_out [ML], e_done [ML];
    logic [NBITS-1:0] e_wd [ML], e_xd [ML];
    logic [SW-1:0]    e_ws [ML];
    bit               d_val [ML], d_start [ML], d_reuse [ML];
    logic [NBITS-1:0] d_msg [ML];
    logic [7:0]       d_nv [ML];
    int               len;

    logic [NBITS-1:0] last_w = '0, last_x = '0;
    logic [SW-1:0]    last_s = '0;
    bit               w_loaded = 0;
    int               word_ctr = 0;

    // One accepted word: optional stall gap, then a handshake at cycle c.
    task automatic feed(input int k, input logic [2:0] s, input int gmax, input bit seq,
                        output int c, output logic [NBITS-1:0] wd);
        int g;
        g = $urandom_range(0, gmax);
        for (int i = 0; i < g; i++) begin
            e_state[k+i] = s;
            d_val[k+i]   = 1'b0;
        end
        c = k + g;
        e_state[c] = s;
        d_val[c]   = 1'b1;
        word_ctr++;
        wd = seq ? NBITS'(word_ctr) : NBITS'($urandom);
        d_msg[c] = wd;
    endtask

    task automatic build_job(input int nv, input bit reuse, input int gmax, input bit seq);
        int k, c;
        logic [NBITS-1:0] wd;
        bit reuse_eff;
        for (int i = 0; i < ML; i++) begin
            e_state[i] = 3'd0; e_wv[i] = 0; e_xv[i] = 0; e_mac[i] = 0; e_out[i] = 0; e_done[i] = 0;
            e_wd[i] = '0; e_xd[i] = '0; e_ws[i] = '0;
            d_val[i] = 1'($urandom_range(0, 1)); d_msg[i] = NBITS'($urandom);
            d_start[i] = 0; d_nv[i] = 8'($urandom); d_reuse[i] = 1'($urandom_range(0, 1));
        end
        reuse_eff = 0;
`ifdef TINYNPU_SEQ_WREUSE_EN
        reuse_eff = reuse && w_loaded;
`endif
        word_ctr   = 0;
        d_start[0] = 1; d_nv[0] = 8'(nv); d_reuse[0] = reuse;
        k = 1;
        if (!reuse_eff) begin
            for (int i = 0; i < SIZE * SIZE; i++) begin
                feed(k, 3'd1, gmax, seq, c, wd);
                e_wv[c+1] = 1; e_wd[c+1] = wd; e_ws[c+1] = SW'(i / SIZE);
                k = c + 1;
            end
            w_loaded = 1;
        end
        for (int v = 0; v < nv; v++) begin
            c = k;
            for (int j = 0; j < SIZE; j++) begin
                feed(k, 3'd2, gmax, seq, c, wd);
                e_xv[c+1] = 1; e_xd[c+1] = wd;
                k = c + 1;
            end
            for (int m = 0; m < MC; m++) begin
                e_state[c+1+m] = 3'd3; e_mac[c+2+m] = 1;
            end
            for (int o = 0; o < SIZE; o++) begin
                e_state[c+1+MC+o] = 3'd4; e_out[c+2+MC+o] = 1;
            end
            k = c + MC + SIZE + 1;
        end
        e_done[k+1] = 1;
        len = k + 2;
        // Starts while busy must be ignored; always place one early if busy.
        if (e_state[2] != 3'd0) d_start[2] = 1;
        for (int i = 3; i < len; i++)
            if (e_state[i] != 3'd0 && $urandom_range(0, 15) == 0) d_start[i] = 1;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_ctl"}, 64'({trace_state, in_rdy, busy, w_load_val, x_load_val, mac_val, out_val, done}), 64'(0));
        check_eq({tag, "_data"}, 64'({w_in, w_load_sel, x_in}), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1; start = 1; in_val = 1; num_vec = 8'd3; reuse_w = 1; in_msg = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            check_idle_zero("rst");
        end
        rst = 0; start = 0; in_val = 0;
        @(negedge clk);
        check_idle_zero("post_rst");
        last_w = '0; last_x = '0; last_s = '0; w_loaded = 0;
    endtask

    task automatic run_job(input int abort_at);
        bit rdy_e, busy_e;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (e_wv[k]) begin last_w = e_wd[k]; last_s = e_ws[k]; end
            if (e_xv[k]) last_x = e_xd[k];
            rdy_e  = (e_state[k] == 3'd1) || (e_state[k] == 3'd2);
            busy_e = (e_state[k] != 3'd0);
            check_eq("ctl", 64'({trace_state, in_rdy, busy, w_load_val, x_load_val, mac_val, out_val, done}),
                     64'({e_state[k], rdy_e, busy_e, e_wv[k], e_xv[k], e_mac[k], e_out[k], e_done[k]}));
            check_eq("data", 64'({w_in, w_load_sel, x_in}), 64'({last_w, last_s, last_x}));
            if (abort_at != 0 && k == abort_at) begin
                do_reset();
                return;
            end
            start = d_start[k]; num_vec = d_nv[k]; reuse_w = d_reuse[k];
            in_val = d_val[k]; in_msg = d_msg[k];
        end
        start = 0; in_val = 0;
    endtask

    task automatic job(input int nv, input bit reuse, input int gmax, input bit seq, input bit abort);
        build_job(nv, reuse, gmax, seq);
        $display("job nv=%0d reuse=%0d gmax=%0d len=%0d abort=%0d", nv, reuse, gmax, len, abort);
        run_job(abort ? len / 2 : 0);
    endtask

    initial begin
        rst = 1; start = 0; num_vec = '0; reuse_w = 0; in_val = 0; in_msg = '0;
        do_reset();
        job(1, 0, 0, 1, 0);   // words 1..20 back-to-back
        job(1, 0, 1, 0, 0);   // stalls during both load phases
        job(3, 0, 1, 0, 0);   // three vectors, mid-job start ignored
        job(0, 0, 0, 0, 0);   // weights only
        job(2, 1, 1, 0, 0);   // weight reuse when enabled
        job(2, 0, 1, 0, 1);   // reset mid-job
        job(1, 1, 0, 0, 0);   // reuse after reset must reload weights
        for (int i = 0; i < 6; i++)
            job($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
